uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side buffer directly downstream of the UART receiver. Captures each
//  received byte on the receiver's one-cycle finish strobe. Holds bytes in a
//  first-word-fall-through queue until the host/consumer drains them over a
//  valid/ready handshake. Reports fill level, threshold and overflow status.
// PARAMETERS
//  DATA_W        8    width of one received character
//  ADDR_W        4    log2(depth); depth = 2**ADDR_W = 16 entries
//  AFULL_THRESH  12   almost_full asserts when level >= this value (1..2**ADDR_W)
// PORTS
//  clk_in       in   1         single system clock; all logic on posedge
//  rst          in   1         synchronous, active-low reset
//  wr_data      in   DATA_W    byte from receiver (rx_data)
//  wr_en        in   1         one-cycle push strobe (receiver rx_finish)
//  rd_data      out  DATA_W    head-of-queue byte, valid while rd_valid=1
//  rd_valid     out  1         queue non-empty; head byte presented
//  rd_ready     in   1         consumer accepts head when rd_valid&rd_ready
//  level        out  ADDR_W+1  number of stored entries, 0..2**ADDR_W
//  full         out  1         level == 2**ADDR_W
//  almost_full  out  1         level >= AFULL_THRESH
//  overflow     out  1         sticky: a push was dropped because queue full
//  ovf_clr      in   1         one-cycle clear of overflow
// BEHAVIOUR
//  - Reset (rst=0 at posedge): wr_ptr=rd_ptr=0, level=0, rd_valid=0, full=0,
//    almost_full=0, overflow=0, rd_data=0. Storage array is not cleared.
//    Reset mid-operation discards all contents; first push afterwards lands at
//    address 0.
//  - pop  = rd_valid & rd_ready; push = wr_en & (~full | pop).
//  - Push writes wr_data at wr_ptr, wr_ptr+1 (mod 2**ADDR_W, natural wrap).
//  - Pop advances rd_ptr+1 (mod 2**ADDR_W).
//  - level: +1 push only, -1 pop only, unchanged on both or neither; never wraps.
//  - FWFT: a byte pushed at edge N gives rd_valid=1 and rd_data=byte after
//    edge N (0 cycles extra latency). rd_data = mem[rd_ptr] when rd_valid,
//    forced 0 when empty.
//  - Flags full/almost_full/rd_valid are registered from next-level.
//    Updated on the same edge as level; no combinational path from wr_en.
//  - Empty + wr_en: push only. rd_ready is ignored while rd_valid=0.
//  - Full + wr_en + pop same cycle: both occur, level stays 2**ADDR_W, no overflow.
//  - Full + wr_en, no pop: byte dropped, contents untouched, overflow<=1.
//  - overflow set and ovf_clr in same cycle: set wins (overflow stays 1).
//  - rd_ready held high with continuous pushes: one byte per cycle streams through.
//  - wr_en is assumed to be a single-cycle strobe. A multi-cycle high wr_en is
//    treated as one push per cycle; no edge detection inside this block.
// STRUCTURE
//  - Shared header uart_defs.vh: UART_DATA_W=8, default FIFO ADDR_W,
//    AFULL_THRESH; the receiver and transmitter sides use the same constants.
//  - Sub-module uart_fifo_mem: 2**ADDR_W x DATA_W register array.
//    Synchronous write port, asynchronous read port.
//  - This block holds the pointers, level counter, flags and overflow logic.
//    uart_fifo_mem is reused by the TX-side FIFO.
// TESTING
//  1 Reset: drive rst=0 2 cycles with wr_en=1 -> level=0, rd_valid=0,
//    overflow=0, rd_data=0.
//  2 Push 0xA5,0x3C,0x7E on separate strobes, rd_ready=0 -> level=3,
//    rd_data=0xA5. Then rd_ready=1 for 3 cycles -> pops A5,3C,7E in order,
//    then rd_valid=0.
//  3 Push 16 bytes 0x00..0x0F -> almost_full at level 12, full at 16.
//    17th push 0xFF -> dropped, overflow=1; drain reads 0x00..0x0F exactly.
//  4 Full queue, wr_en=0x55 with rd_ready=1 same cycle -> level stays 16,
//    overflow stays 0. Drain: 0x55 is the last byte read.
//  5 Wrap: push/pop 40 bytes, rd_ready=1, one push per cycle -> every byte out
//    1:1 in order, level <= 1; pointers wrap twice without loss.
//  6 overflow=1, ovf_clr=1 coincident with a dropped push -> overflow stays 1.
//    ovf_clr alone -> overflow=0. Reset at level 7 -> level=0, next push is
//    read back first.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared UART character width and FIFO sizing constants
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int FIFO_ADDR_W       = 4;
  localparam int FIFO_AFULL_THRESH = 12;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - 2**ADDR_W x DATA_W register array, sync write, async read
module uart_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // No reset: contents are only meaningful between the FIFO's pointers.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT receive FIFO with level, threshold and sticky overflow
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W       = UART_DATA_W,
  parameter int ADDR_W       = FIFO_ADDR_W,
  parameter int AFULL_THRESH = FIFO_AFULL_THRESH
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] LP_AFULL = (ADDR_W+1)'(AFULL_THRESH);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_valid;
  logic              r_full;
  logic              r_afull;
  logic              r_overflow;

  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [ADDR_W:0]   w_level_nxt;
  logic [DATA_W-1:0] w_mem_rd;

  assign w_pop  = r_valid & rd_ready;
  assign w_push = wr_en & (~r_full | w_pop);
  assign w_drop = wr_en & r_full & ~w_pop;

  always_comb begin
    w_level_nxt = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + (ADDR_W+1)'(1);
      2'b01:   w_level_nxt = r_level - (ADDR_W+1)'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Flags come from the next level so they change on the same edge as level.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_valid    <= 1'b0;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != '0);
      r_full  <= (w_level_nxt == LP_DEPTH);
      r_afull <= (w_level_nxt >= LP_AFULL);
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .i_clk     (clk_in),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_mem_rd)
  );

  assign rd_data     = r_valid ? w_mem_rd : '0;
  assign rd_valid    = r_valid;
  assign level       = r_level;
  assign full        = r_full;
  assign almost_full = r_afull;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic       clk_in = 1'b0;
  logic       rst, wr_en, rd_ready, ovf_clr;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, full, almost_full, overflow;
  logic [4:0] level;

  always #5 clk_in = ~clk_in;

  uart_rx_fifo dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .level       (level),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  int         n_pass  = 0;
  int         n_total = 0;
  int         n_pops  = 0;
  logic [7:0] last_pop;
  logic [7:0] sb[$];
  logic       m_ovf = 1'b0;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] d;
    logic       rr;
    logic       clr;
    int         lvl;
    logic       vld;
    logic [7:0] rdat;
    logic       ovf;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input logic r_v, input logic w_v, input logic [7:0] d,
                     input logic rr_v, input logic c_v);
    logic       m_full, m_pop, m_push;
    logic [7:0] head;
    rst = r_v; wr_en = w_v; wr_data = d; rd_ready = rr_v; ovf_clr = c_v;
    m_full = (sb.size() == 16);
    m_pop  = r_v && rr_v && (sb.size() != 0);
    m_push = w_v && (!m_full || m_pop);
    if (m_pop) begin
      head = sb.pop_front();
      chk("pop_data", int'(rd_data), int'(head));
      last_pop = rd_data;
      n_pops++;
    end
    if (!r_v) begin
      sb.delete();
      m_ovf = 1'b0;
    end else begin
      if (m_push) sb.push_back(d);
      if (w_v && m_full && !m_pop) m_ovf = 1'b1;
      else if (c_v)                m_ovf = 1'b0;
    end
    @(posedge clk_in);
    #1;
    chk("level", int'(level), sb.size());
    chk("rd_valid", int'(rd_valid), int'(sb.size() != 0));
    chk("full", int'(full), int'(sb.size() == 16));
    chk("almost_full", int'(almost_full), int'(sb.size() >= 12));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("rd_data", int'(rd_data), (sb.size() != 0) ? int'(sb[0]) : 0);
  endtask

  initial begin
    //              rst  wr   d      rr   clr  lvl vld rdat   ovf
    tbl[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 2, 1'b1, 8'hA5, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b1, 8'hA5, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'h7E, 1'b0, 1'b0, 3, 1'b1, 8'hA5, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'h3C, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h7E, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1, 1'b1, 8'h5A, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].rst, tbl[i].wr, tbl[i].d, tbl[i].rr, tbl[i].clr);
      chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].lvl);
      chk($sformatf("tbl%0d_valid", i), int'(rd_valid), int'(tbl[i].vld));
      chk($sformatf("tbl%0d_rdata", i), int'(rd_data), int'(tbl[i].rdat));
      chk($sformatf("tbl%0d_ovf", i), int'(overflow), int'(tbl[i].ovf));
    end

    // Fill to full, threshold crossing, dropped 17th push, ordered drain.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 10) chk("afull_at_11", int'(almost_full), 0);
      if (i == 11) chk("afull_at_12", int'(almost_full), 1);
      if (i == 14) chk("full_at_15", int'(full), 0);
    end
    chk("full_at_16", int'(full), 1);
    cyc(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    chk("drop_ovf", int'(overflow), 1);
    chk("drop_level", int'(level), 16);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain3_last", int'(last_pop), 8'h0F);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

    // Push while full with a simultaneous pop.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
    chk("fullpop_level", int'(level), 16);
    chk("fullpop_ovf", int'(overflow), 0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("fullpop_last", int'(last_pop), 8'h55);

    // Streaming through with pointer wrap.
    n_pops = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b1, 8'(i * 7 + 3), 1'b1, 1'b0);
      if (level > 5'd1) chk("stream_level_le1", int'(level), 1);
    end
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_count", n_pops, 40);
    chk("stream_last", int'(last_pop), 8'(39 * 7 + 3));

    // Overflow set beats clear; clear alone; reset mid-operation.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    cyc(1'b1, 1'b1, 8'hEF, 1'b0, 1'b1);
    chk("ovf_set_wins", int'(overflow), 1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", int'(overflow), 0);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_reset_level", int'(level), 7);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset_level", int'(level), 0);
    chk("reset_rdata", int'(rd_data), 0);
    cyc(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
    chk("post_reset_head", int'(rd_data), 8'hC3);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_reset_pop", int'(last_pop), 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
